// File: rtl/dcache_mem_system.sv
// -----------------------------------------------------------------------------
// dcache_mem_system
//
// Direct-mapped, write-through, no-write-allocate data cache in front of a
// flop-based backing memory with a fixed access latency. Each line has one
// valid bit and one tag. A read miss fills the whole line when the memory
// access completes. A write always goes to memory, and it also updates the
// cached word when the address is resident.
//
// Ports
//   clk       rising-edge clock
//   RST       synchronous active-low reset
//   MemRead   load request (held stable by the core while stall=1)
//   MemWrite  store request (held stable while stall=1; wins over MemRead)
//   WA        word address {tag, index, offset}
//   BE        store byte enables, BE[i] -> Data_in[8i+7:8i]
//   Data_in   store data
//   inv       invalidate-all request (honoured in IDLE only)
//   stall     core must hold its state this cycle
//   Data_out  load data, 0 whenever no read data is valid
//   hit_cnt   saturating read-hit counter
//   miss_cnt  saturating read-miss counter
// -----------------------------------------------------------------------------
module dcache_mem_system #(
   parameter int ADDR_W   = 10,
   parameter int INDEX_W  = 5,
   parameter int OFFSET_W = 2,
   parameter int MEM_LAT  = 4,
   parameter int CNT_W    = 16
) (
   input  logic              clk,
   input  logic              RST,
   input  logic              MemRead,
   input  logic              MemWrite,
   input  logic [ADDR_W-1:0] WA,
   input  logic [3:0]        BE,
   input  logic [31:0]       Data_in,
   input  logic              inv,
   output logic              stall,
   output logic [31:0]       Data_out,
   output logic [CNT_W-1:0]  hit_cnt,
   output logic [CNT_W-1:0]  miss_cnt
);

   localparam int TAG_W     = ADDR_W - INDEX_W - OFFSET_W;
   localparam int LINES     = 1 << INDEX_W;
   localparam int WORDS     = 1 << OFFSET_W;
   localparam int MEM_WORDS = 1 << ADDR_W;
   localparam int LAT_W     = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_MISS = 2'd1,
      WR      = 2'd2
   } state_t;

   state_t state;
   state_t next_state;

   logic [LAT_W-1:0]    lat_cnt;
   logic                lat_last;

   logic [TAG_W-1:0]    tag_f;
   logic [INDEX_W-1:0]  index_f;
   logic [OFFSET_W-1:0] offset_f;

   logic [LINES-1:0]    valid;
   logic [TAG_W-1:0]    tag_arr  [LINES];
   logic [31:0]         data_arr [LINES][WORDS];
   logic [31:0]         mem      [MEM_WORDS];

   logic                hit;
   logic [31:0]         cached_word;
   logic [31:0]         mem_word;

   logic                idle;
   logic                inv_ev;
   logic                rd_req;
   logic                rd_hit_ev;
   logic                rd_miss_ev;
   logic                fill_ev;
   logic                wr_done_ev;

   // Replace only the enabled bytes of old_w with those of new_w.
   function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  en);
      logic [31:0] r;
      r = old_w;
      for (int b = 0; b < 4; b++) begin
         if (en[b]) r[8*b +: 8] = new_w[8*b +: 8];
      end
      return r;
   endfunction

   // ---------------------------------------------------------------------------
   // Address split and lookup
   // ---------------------------------------------------------------------------
   assign tag_f    = WA[ADDR_W-1 -: TAG_W];
   assign index_f  = WA[OFFSET_W +: INDEX_W];
   assign offset_f = WA[OFFSET_W-1:0];

   // Tags of invalid lines may be X after power-up; the valid bit masks them.
   assign hit         = valid[index_f] && (tag_arr[index_f] == tag_f);
   assign cached_word = data_arr[index_f][offset_f];
   assign mem_word    = mem[WA];

   assign lat_last = (lat_cnt == LAT_W'(MEM_LAT - 1));

   // Request decode in IDLE: inv beats MemWrite beats MemRead.
   assign idle       = (state == IDLE);
   assign inv_ev     = idle && inv;
   assign rd_req     = idle && !inv && !MemWrite && MemRead;
   assign rd_hit_ev  = rd_req && hit;
   assign rd_miss_ev = rd_req && !hit;
   assign fill_ev    = (state == RD_MISS) && lat_last;
   assign wr_done_ev = (state == WR) && lat_last;

   // ---------------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking (<=) so every flop samples the
   // pre-edge values, independent of process ordering.
   always_ff @(posedge clk) begin
      if (!RST) state <= IDLE;
      else      state <= next_state;
   end

   // ---------------------------------------------------------------------------
   // FSM: next-state logic
   // ---------------------------------------------------------------------------
   // NOTE: every variable written in always_comb gets a default first so no
   // path leaves it unassigned (which would infer a latch).
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (inv)                  next_state = IDLE;
            else if (MemWrite)        next_state = WR;
            else if (MemRead && !hit) next_state = RD_MISS;
         end
         RD_MISS: if (lat_last) next_state = IDLE;
         WR:      if (lat_last) next_state = IDLE;
         default:               next_state = IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // FSM: outputs
   // ---------------------------------------------------------------------------
   always_comb begin
      stall    = 1'b0;
      Data_out = '0;
      case (state)
         IDLE: begin
            if (inv || MemWrite) begin
               stall = 1'b1;
            end else if (MemRead) begin
               if (hit) Data_out = cached_word;
               else     stall    = 1'b1;
            end
         end
         // The final RD_MISS cycle forwards the memory word directly; the
         // line itself is written at the closing edge.
         RD_MISS: begin
            if (lat_last) Data_out = mem_word;
            else          stall    = 1'b1;
         end
         WR:      stall = !lat_last;
         default: ;
      endcase
      // Outputs are quiet while reset is held, whatever the state.
      if (!RST) begin
         stall    = 1'b0;
         Data_out = '0;
      end
   end

   // ---------------------------------------------------------------------------
   // Latency counter, valid bits, statistics
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!RST) begin
         lat_cnt  <= '0;
         valid    <= '0;
         hit_cnt  <= '0;
         miss_cnt <= '0;
      end else begin
         // Held at 0 in IDLE so it is 0 on entry to RD_MISS or WR.
         if (idle || lat_last) lat_cnt <= '0;
         else                  lat_cnt <= lat_cnt + LAT_W'(1);

         if (inv_ev)       valid          <= '0;
         else if (fill_ev) valid[index_f] <= 1'b1;

         if (rd_hit_ev && (hit_cnt != {CNT_W{1'b1}}))
            hit_cnt <= hit_cnt + CNT_W'(1);
         if (rd_miss_ev && (miss_cnt != {CNT_W{1'b1}}))
            miss_cnt <= miss_cnt + CNT_W'(1);
      end
   end

   // ---------------------------------------------------------------------------
   // Cache tag/data arrays
   // ---------------------------------------------------------------------------
   // NOTE: tag and data arrays are deliberately not reset; the valid bits
   // qualify them, so clearing them would only cost reset fan-out. Writes are
   // still gated by RST so a reset mid-operation aborts the fill.
   always_ff @(posedge clk) begin
      if (RST) begin
         if (fill_ev) begin
            tag_arr[index_f] <= tag_f;
            for (int w = 0; w < WORDS; w++) begin
               data_arr[index_f][w] <= mem[{tag_f, index_f, OFFSET_W'(w)}];
            end
         end else if (wr_done_ev && hit) begin
            // Write-through hit: keep the cached copy coherent with memory.
            data_arr[index_f][offset_f] <= byte_merge(cached_word, Data_in, BE);
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Backing memory (cleared by reset)
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!RST) begin
         for (int i = 0; i < MEM_WORDS; i++) begin
            mem[i] <= '0;
         end
      end else if (wr_done_ev) begin
         mem[WA] <= byte_merge(mem_word, Data_in, BE);
      end
   end

endmodule

// File: doc/dcache_mem_system.md
DCACHE_MEM_SYSTEM -- requirements
Module: dcache_mem_system

Interface
REQ-001 Parameter ADDR_W, default 10, meaning word-address width; backing memory holds 2^ADDR_W 32-bit words.
REQ-002 Parameter INDEX_W, default 5, meaning cache index width; the cache has 2^INDEX_W direct-mapped lines.
REQ-003 Parameter OFFSET_W, default 2, meaning word-offset width; each line holds 2^OFFSET_W words. TAG_W = ADDR_W-INDEX_W-OFFSET_W, which must be >= 1.
REQ-004 Parameter MEM_LAT, default 4, meaning backing-memory access latency in cycles; MEM_LAT >= 1.
REQ-005 Parameter CNT_W, default 16, meaning statistics counter width.
REQ-006 clk  input  1  the single clock; all state updates occur on the rising edge.
REQ-007 RST  input  1  reset, synchronous and active-low.
REQ-008 MemRead  input  1  load request; held stable by the core while stall=1.
REQ-009 MemWrite  input  1  store request; held stable while stall=1.
REQ-010 WA  input  ADDR_W  word address; split as {tag, index, offset}.
REQ-011 BE  input  4  byte enables for stores; BE[i] selects Data_in[8i+7:8i].
REQ-012 Data_in  input  32  store data.
REQ-013 inv  input  1  invalidate-all request.
REQ-014 stall  output  1  the core must hold its state this cycle.
REQ-015 Data_out  output  32  load data.
REQ-016 hit_cnt  output  CNT_W  read-hit count.
REQ-017 miss_cnt  output  CNT_W  read-miss count.

Function
REQ-018 The block SHALL be a direct-mapped, write-through, no-write-allocate cache with one valid bit and one tag per line.
REQ-019 The FSM SHALL have the states IDLE, RD_MISS and WR, plus a latency counter lat_cnt that is 0 on entry to RD_MISS or WR.
REQ-020 Request priority in IDLE SHALL be: inv, then MemWrite, then MemRead; if MemWrite and MemRead are both high, the request SHALL be treated as a write.
REQ-021 IDLE with inv=1: all valid bits SHALL clear at the edge, stall=1 for that cycle, the state SHALL stay IDLE, and any concurrent access SHALL be re-evaluated in the next cycle.
REQ-022 inv SHALL be ignored in RD_MISS and WR.
REQ-023 IDLE read hit (valid and tag match): stall=0, Data_out = the cached word combinationally in the same cycle, hit_cnt+1.
REQ-024 IDLE read miss: stall=1, the FSM SHALL go to RD_MISS, miss_cnt+1 (one increment per miss).
REQ-025 RD_MISS: lat_cnt SHALL increment each cycle with stall=1 while lat_cnt < MEM_LAT-1.
REQ-026 When lat_cnt = MEM_LAT-1 in RD_MISS: stall=0, Data_out = the addressed memory word, and at the edge the whole line, tag and valid=1 SHALL be written; the FSM SHALL return to IDLE.
REQ-027 Read miss timing: stall SHALL be high for exactly MEM_LAT cycles (request cycle plus MEM_LAT-1 RD_MISS cycles), with data on the following cycle.
REQ-028 IDLE write: stall=1 and the FSM SHALL go to WR; in WR, stall=1 while lat_cnt < MEM_LAT-1.
REQ-029 When lat_cnt = MEM_LAT-1 in WR: stall=0, and at the edge the memory word SHALL be updated under BE.
REQ-030 If the write address hits at that point, the cached word SHALL be updated under BE at the same edge; a write miss SHALL NOT allocate a line. The FSM SHALL then return to IDLE.
REQ-031 When MemWrite=1, BE=0000, the write SHALL still take MEM_LAT stall cycles but modify nothing.
REQ-032 Data_out SHALL be 0 whenever no read data is valid: IDLE without a read hit, during stall=1, and during writes.
REQ-033 hit_cnt and miss_cnt SHALL saturate at 2^CNT_W-1 and not wrap.
REQ-034 With MemRead=MemWrite=inv=0 in IDLE, stall SHALL be 0 and no state SHALL change.

Reset
REQ-035 RST=0 at an edge SHALL set: state IDLE, lat_cnt 0, all valid bits 0, hit_cnt 0, miss_cnt 0, all backing-memory words 0.
REQ-036 Cache data and tag arrays SHALL NOT be reset.
REQ-037 While RST=0, outputs SHALL be stall=0 and Data_out=0.
REQ-038 Reset during RD_MISS or WR SHALL abort the operation: no line fill and no memory write.

Verification
REQ-039 Reset, then read WA=0x004 -> stall high 4 cycles; Data_out=0 on the 5th cycle with stall=0; miss_cnt=1; immediate re-read of WA=0x005 -> hit, stall=0, hit_cnt=1.
REQ-040 Write 0xDEADBEEF to WA=0x010 with BE=1111 (miss) -> 4 stall cycles, no allocation; read 0x010 -> miss, returns 0xDEADBEEF.
REQ-041 After REQ-040, write 0x000000AA to WA=0x010 with BE=0001 (hit) -> a subsequent read hits and returns 0xDEADBEAA.
REQ-042 Read 0x004, then read 0x084 (same index, different tag) -> both miss; a re-read of 0x004 misses again (eviction); miss_cnt=3.
REQ-043 Fill a line, assert inv together with MemRead -> stall=1 for 1 cycle, then a full read miss; RST=0 asserted at lat_cnt=1 of a write -> the memory word remains 0.
REQ-044 Force hit_cnt to 0xFFFF (CNT_W=16) -> a further read hit leaves it at 0xFFFF.
